// File: rtl/ex3_to_bin_seq.sv
// Multi-digit excess-3 to binary converter, one digit per clock.
// Digits arrive packed MSD-first; result returns with an invalid-code flag.
module ex3_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   ex3_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int SH_W  = 4 * DIGITS;
    localparam int CNT_W = (DIGITS < 2) ? 1 : $clog2(DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [SH_W-1:0]    r_shift;
    logic [BIN_W-1:0]   r_acc;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_release;
    logic               w_last;
    logic [3:0]         w_digit;
    logic               w_code_ok;
    logic [3:0]         w_value;
    logic [BIN_W-1:0]   w_addend;
    logic [BIN_W-1:0]   w_acc_x10;
    logic [BIN_W-1:0]   w_acc_next;

    // Handshake events are qualified by the registered state only.
    assign w_accept  = in_valid & in_ready;
    assign w_release = out_valid & out_ready;
    assign w_last    = (r_cnt == CNT_W'(DIGITS - 1));

    // Digit decode: top nibble of the shift register, codes 3..12 legal.
    assign w_digit   = r_shift[SH_W-1 -: 4];
    assign w_code_ok = (w_digit >= 4'd3) && (w_digit <= 4'd12);
    assign w_value   = w_code_ok ? (w_digit - 4'd3) : 4'd0;
    assign w_addend  = BIN_W'(w_value);

    // acc*10 as shift-and-add, kept at BIN_W bits.
    assign w_acc_x10  = (r_acc << 3) + (r_acc << 1);
    assign w_acc_next = w_acc_x10 + w_addend;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_CONV;
                end
            end
            S_CONV: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: load on accept, fold one digit per CONV cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_acc   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shift <= ex3_in;
            r_acc   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == S_CONV) begin
            r_shift <= r_shift << 4;
            r_acc   <= w_acc_next;
            r_err   <= r_err | ~w_code_ok;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Result is exposed only while holding a finished word.
    assign bin_out = (out_valid && !r_err) ? r_acc : '0;
    assign err     = out_valid & r_err;

    logic w_unused;
    assign w_unused = w_release;

endmodule

// File: tb/tb_ex3_to_bin_seq.sv
// Directed bench for ex3_to_bin_seq (DIGITS=4, BIN_W=14).
// Hand-computed vectors, checked with immediate assertions.
module tb_ex3_to_bin_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ex3_in;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] bin_out;
    logic        err;

    int errors = 0;
    int checks = 0;

    ex3_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ex3_in    (ex3_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_word(input logic [15:0] w, input logic [13:0] eb,
                            input logic ee, input int hold,
                            input string tag);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("%s_idle_rdy", tag), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid  = 1'b1;
        ex3_in    = w;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ex3_in   = ~w;
        chk($sformatf("%s_busy", tag), 32'(in_ready), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_lat%0d", tag, k), 32'(out_valid),
                32'(k == 4));
        end
        chk($sformatf("%s_bin", tag), 32'(bin_out), 32'(eb));
        chk($sformatf("%s_err", tag), 32'(err), 32'(ee));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_hold_bin", tag), 32'(bin_out), 32'(eb));
            chk($sformatf("%s_hold_err", tag), 32'(err), 32'(ee));
            chk($sformatf("%s_hold_ov", tag), 32'(out_valid), 32'd1);
            chk($sformatf("%s_hold_ir", tag), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk($sformatf("%s_ov_drop", tag), 32'(out_valid), 32'd0);
        chk($sformatf("%s_ir_back", tag), 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ex3_in    = 16'h0000;
        #12;
        chk("rst_ir", 32'(in_ready), 32'd1);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_bin", 32'(bin_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_word(16'h6789, 14'd3456, 1'b0, 0, "nom");
        run_word(16'h3333, 14'd0, 1'b0, 0, "zero");
        run_word(16'hCCCC, 14'd9999, 1'b0, 0, "max");
        run_word(16'h3334, 14'd1, 1'b0, 0, "one");
        run_word(16'h3F33, 14'd0, 1'b1, 0, "badF");
        run_word(16'h0333, 14'd0, 1'b1, 0, "bad0");
        run_word(16'hC3C3, 14'd9090, 1'b0, 0, "c3c3");
        run_word(16'h6789, 14'd3456, 1'b0, 10, "bp");

        // Async reset while a result is being held.
        @(negedge clk);
        in_valid = 1'b1;
        ex3_in   = 16'h4444;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("done_ov", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ov", 32'(out_valid), 32'd0);
        chk("arst_ir", 32'(in_ready), 32'd1);
        chk("arst_bin", 32'(bin_out), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Async reset two cycles into a conversion.
        @(negedge clk);
        in_valid = 1'b1;
        ex3_in   = 16'h6789;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_ov", 32'(out_valid), 32'd0);
        chk("mid_ir", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("mid_no_ov", 32'(out_valid), 32'd0);
        end
        run_word(16'h4444, 14'd1111, 1'b0, 0, "after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
